// File: rtl/ucie_link_retrain_fsm.sv
// UCIe link-training sequencer: RESET..ACTIVE with speed negotiation, degrade-on-error and bounded retrain.
// Build option UCIE_LTSM_WIDTH_DEGRADE_EN enables halving the lane width before dropping speed.
module ucie_link_retrain_fsm #(
   parameter int NUM_LANES  = 64,
   parameter int NUM_SPEEDS = 6,
   parameter int MAX_RETRY  = 4,
   parameter int TIMER_W    = 24,
   parameter int SPD_W      = $clog2(NUM_SPEEDS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 train_start,
   input  logic                 retrain_req,
   input  logic [TIMER_W-1:0]   cfg_timeout,
   input  logic [SPD_W-1:0]     cfg_max_speed,
   input  logic                 phy_ready,
   output logic                 param_tx_valid,
   output logic [SPD_W-1:0]     param_tx_data,
   input  logic                 param_tx_ready,
   input  logic                 param_rx_valid,
   input  logic [SPD_W-1:0]     param_rx_speed,
   output logic                 cal_start,
   input  logic                 cal_done,
   input  logic                 cal_error,
   output logic                 lane_train_en,
   input  logic [NUM_LANES-1:0] lane_done,
   input  logic [NUM_LANES-1:0] lane_err,
   output logic [NUM_LANES-1:0] lane_enable,
   output logic [SPD_W-1:0]     speed_idx,
   output logic [3:0]           state,
   output logic                 link_up,
   output logic                 link_fail,
   output logic [7:0]           retry_count
);

   localparam logic [3:0] S_RESET    = 4'd0;
   localparam logic [3:0] S_SBINIT   = 4'd1;
   localparam logic [3:0] S_PARAM    = 4'd2;
   localparam logic [3:0] S_MBINIT   = 4'd3;
   localparam logic [3:0] S_CAL      = 4'd4;
   localparam logic [3:0] S_MBTRAIN  = 4'd5;
   localparam logic [3:0] S_LINKINIT = 4'd6;
   localparam logic [3:0] S_ACTIVE   = 4'd7;
   localparam logic [3:0] S_RETRAIN  = 4'd8;
   localparam logic [3:0] S_ERROR    = 4'd9;

   localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

   logic [3:0]           state_q, next_state, deg_state;
   logic [TIMER_W-1:0]   timer_q;
   logic [SPD_W-1:0]     speed_q, speed_d, deg_speed, remote_speed_q, tx_data_q;
   logic [NUM_LANES-1:0] lane_en_q, lane_en_d, deg_lanes, err_vec;
   logic [7:0]           retry_q;
   logic                 exhaust_q, offer_q, remote_q;
   logic                 any_err, all_done, timed_out;

   assign err_vec   = lane_err & lane_en_q;
   assign any_err   = |err_vec;
   assign all_done  = &(lane_done | ~lane_en_q);
   assign timed_out = (cfg_timeout != '0) && (timer_q == cfg_timeout);

`ifdef UCIE_LTSM_WIDTH_DEGRADE_EN
   localparam logic [NUM_LANES-1:0] LOWER_MASK = {{(NUM_LANES/2){1'b0}}, {(NUM_LANES/2){1'b1}}};
   logic width_full, upper_only;
   assign width_full = &lane_en_q;
   assign upper_only = (err_vec[NUM_LANES/2-1:0] == '0);
`endif

   // Degrade outcome: halve width if only the upper half failed, else drop one speed grade, else give up.
   always_comb begin
      deg_state = S_ERROR;
      deg_speed = speed_q;
      deg_lanes = lane_en_q;
`ifdef UCIE_LTSM_WIDTH_DEGRADE_EN
      if (width_full && upper_only) begin
         deg_state = S_RETRAIN;
         deg_lanes = LOWER_MASK;
      end else
`endif
      if (speed_q != '0) begin
         deg_state = S_RETRAIN;
         deg_speed = speed_q - SPD_W'(1);
      end
   end

   always_comb begin
      next_state = state_q;
      speed_d    = speed_q;
      lane_en_d  = lane_en_q;
      case (state_q)
         S_RESET:    if (train_start && phy_ready) next_state = S_SBINIT;
         S_SBINIT:   if (timed_out) next_state = S_ERROR;
                     else if (phy_ready) next_state = S_PARAM;
         S_PARAM:    if (timed_out) next_state = S_ERROR;
                     else if (offer_q && remote_q) begin
                        next_state = S_MBINIT;
                        speed_d    = (cfg_max_speed < remote_speed_q) ? cfg_max_speed : remote_speed_q;
                     end
         S_MBINIT:   if (timed_out) next_state = S_ERROR;
                     else if (phy_ready) next_state = S_CAL;
         S_CAL:      if (timed_out || cal_error) next_state = S_ERROR;
                     else if (cal_done) next_state = S_MBTRAIN;
         S_MBTRAIN:  if (timed_out) next_state = S_ERROR;
                     else if (any_err) begin
                        next_state = deg_state;
                        speed_d    = deg_speed;
                        lane_en_d  = deg_lanes;
                     end else if (all_done) next_state = S_LINKINIT;
         S_LINKINIT: if (timed_out) next_state = S_ERROR;
                     else if (all_done) next_state = S_ACTIVE;
         S_ACTIVE:   if (any_err) begin
                        next_state = deg_state;
                        speed_d    = deg_speed;
                        lane_en_d  = deg_lanes;
                     end else if (retrain_req) next_state = S_RETRAIN;
         S_RETRAIN:  next_state = exhaust_q ? S_ERROR : S_MBINIT;
         S_ERROR:    if (train_start) next_state = S_RESET;
         default:    next_state = S_RESET;
      endcase
      if (next_state == S_RESET && state_q != S_RESET) begin
         lane_en_d = '1;
         speed_d   = cfg_max_speed;
      end
   end

   // The retry limit is judged on the count before this entry, so MAX_RETRY retrains succeed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_RESET;
         timer_q        <= '0;
         speed_q        <= '0;
         lane_en_q      <= '1;
         retry_q        <= '0;
         exhaust_q      <= 1'b0;
         offer_q        <= 1'b0;
         remote_q       <= 1'b0;
         remote_speed_q <= '0;
         tx_data_q      <= '0;
      end else begin
         state_q   <= next_state;
         speed_q   <= speed_d;
         lane_en_q <= lane_en_d;
         tx_data_q <= cfg_max_speed;
         if (next_state != state_q) timer_q <= '0;
         else if (timer_q != '1) timer_q <= timer_q + TIMER_W'(1);
         if (next_state == S_RESET && state_q != S_RESET) begin
            retry_q   <= '0;
            exhaust_q <= 1'b0;
         end else if (next_state == S_RETRAIN && state_q != S_RETRAIN) begin
            exhaust_q <= (retry_q >= RETRY_LIMIT);
            if (retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
         end
         if (next_state == S_PARAM && state_q != S_PARAM) begin
            offer_q  <= 1'b0;
            remote_q <= 1'b0;
         end else if (state_q == S_PARAM) begin
            if (param_tx_ready) offer_q <= 1'b1;
            if (param_rx_valid && !remote_q) begin
               remote_q       <= 1'b1;
               remote_speed_q <= param_rx_speed;
            end
         end
      end
   end

   assign state          = state_q;
   assign speed_idx      = speed_q;
   assign lane_enable    = lane_en_q;
   assign retry_count    = retry_q;
   assign param_tx_data  = tx_data_q;
   assign param_tx_valid = (state_q == S_PARAM);
   assign cal_start      = (state_q == S_CAL);
   assign lane_train_en  = (state_q == S_MBTRAIN);
   assign link_up        = (state_q == S_ACTIVE);
   assign link_fail      = (state_q == S_ERROR);

endmodule
